// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU op codes, default
// widths and the result-slot FSM state type.
package alu_share_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int OP_W_DEF = 4;

  // Op codes of the shared ALU. Codes 11..15 are undefined and return the
  // marker value below; ALU_INVALID is the canonical undefined code.
  localparam logic [OP_W_DEF-1:0] ALU_NOP     = 4'h0;
  localparam logic [OP_W_DEF-1:0] ALU_ADD     = 4'h1;
  localparam logic [OP_W_DEF-1:0] ALU_SUB     = 4'h2;
  localparam logic [OP_W_DEF-1:0] ALU_SLT     = 4'h3;
  localparam logic [OP_W_DEF-1:0] ALU_SLTU    = 4'h4;
  localparam logic [OP_W_DEF-1:0] ALU_SLL     = 4'h5;
  localparam logic [OP_W_DEF-1:0] ALU_SRL     = 4'h6;
  localparam logic [OP_W_DEF-1:0] ALU_SRA     = 4'h7;
  localparam logic [OP_W_DEF-1:0] ALU_AND     = 4'h8;
  localparam logic [OP_W_DEF-1:0] ALU_OR      = 4'h9;
  localparam logic [OP_W_DEF-1:0] ALU_XOR     = 4'hA;
  localparam logic [OP_W_DEF-1:0] ALU_INVALID = 4'hF;

  localparam logic [31:0] ALU_BAD_RESULT = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational shared ALU.
//   a, b   : operands (XLEN)
//   op     : operation select (OP_W), codes from alu_share_arbiter_pkg
//   result : ALU output (XLEN); undefined codes give ALU_BAD_RESULT
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] result
);

  localparam int SH_W = $clog2(XLEN);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [SH_W-1:0] shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = XLEN'(ALU_BAD_RESULT);
    case (op)
      ALU_NOP:  result = '0;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = a_s >>> shamt;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      default:  result = XLEN'(ALU_BAD_RESULT);
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_grant.sv
// Round-robin grant: first valid requester at or after the pointer,
// wrapping modulo NUM_REQ. The pointer moves past the winner only when
// the grant is actually taken (advance).
//   clk, rst  : clock, asynchronous active-high reset (pointer -> 0)
//   valid     : request bits, one per requester
//   advance   : grant accepted this cycle
//   grant     : index of the winning requester
//   grant_vld : at least one requester is valid
module alu_share_arbiter_rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_vld
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;

  // Walk from the lowest priority back to the pointer so the last hit wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (int'(ptr) + k >= NUM_REQ) idx = IDX_W'(int'(ptr) + k - NUM_REQ);
      else                          idx = IDX_W'(int'(ptr) + k);
      if (valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration
// and a single registered result slot.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : request present per requester
//   req_ready  : request accepted this cycle (only the granted bit can be 1)
//   req_a/b    : packed operands, requester i at [i*XLEN +: XLEN]
//   req_op     : packed op codes, requester i at [i*OP_W +: OP_W]
//   rsp_valid  : result available, one-hot on the slot owner or zero
//   rsp_ready  : consume strobe per requester (only the owner's bit matters)
//   rsp_result : registered ALU result, held after drain
//   op_count   : accepted request count, wraps at 2^32
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF,
  parameter int OP_W    = OP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_result,
  output logic [31:0]             op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  slot_state_e      state;
  slot_state_e      state_n;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant;
  logic             grant_vld;
  logic             drain;
  logic             slot_free;
  logic             accept;

  logic        [XLEN-1:0]    a_p0;
  logic        [XLEN-1:0]    b_p0;
  logic        [OP_W-1:0]    op_p0;
  logic        [XLEN-1:0]    alu_p0;
  logic        [XLEN-1:0]    result_p1;
  logic        [NUM_REQ-1:0] vld_p1;

  assign drain     = (state == HOLD) && rsp_ready[owner];
  assign slot_free = (state == IDLE) || drain;
  // Nothing is accepted while reset is held, even between edges.
  assign accept    = grant_vld && slot_free && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  alu_share_arbiter_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // ---- stage p0: grant-indexed operand mux into the shared ALU ----
  assign a_p0  = req_a[grant*XLEN +: XLEN];
  assign b_p0  = req_b[grant*XLEN +: XLEN];
  assign op_p0 = req_op[grant*OP_W +: OP_W];

  alu_share_arbiter_alu #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_alu (
    .a      (a_p0),
    .b      (b_p0),
    .op     (op_p0),
    .result (alu_p0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = HOLD;
      HOLD:    if (accept) state_n = HOLD;
               else if (drain) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---- stage p1: registered result slot ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p1 <= '0;
      vld_p1    <= '0;
      owner     <= '0;
      op_count  <= '0;
    end else if (accept) begin
      result_p1 <= alu_p0;
      vld_p1    <= NUM_REQ'(1) << grant;
      owner     <= grant;
      op_count  <= op_count + 32'd1;
    end else if (drain) begin
      vld_p1    <= '0;
    end
  end

  assign rsp_result = result_p1;
  assign rsp_valid  = vld_p1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int OP_W    = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_a;
  logic [NUM_REQ*XLEN-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [XLEN-1:0]         rsp_result;
  logic [31:0]             op_count;

  alu_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .XLEN    (XLEN),
    .OP_W    (OP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int          m_ptr;
  logic [31:0] m_count;
  int          checks = 0;
  int          errors = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [31:0] r;
    case (op)
      4'h0: r = 32'h0;
      4'h1: r = a + b;
      4'h2: r = a - b;
      4'h3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h4: r = (a < b) ? 32'd1 : 32'd0;
      4'h5: r = a << b[4:0];
      4'h6: r = a >> b[4:0];
      4'h7: r = $unsigned($signed(a) >>> b[4:0]);
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      default: r = 32'hDEADBEEF;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    req_valid[i]            = v;
    req_a[i*XLEN +: XLEN]   = a;
    req_b[i*XLEN +: XLEN]   = b;
    req_op[i*OP_W +: OP_W]  = op;
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr   = 0;
    m_count = 32'h0;
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, then let the
  // model take the same handshakes the edge will take.
  task automatic step();
    logic [NUM_REQ-1:0] exp_vld;
    logic [NUM_REQ-1:0] exp_rdy;
    logic               free;
    int                 g;
    int                 idx;
    @(negedge clk);
    exp_vld = (sb.size() != 0) ? NUM_REQ'(1) << sb[0].owner : '0;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    if (sb.size() != 0) check("rsp_result", rsp_result, sb[0].res);
    check("op_count", op_count, m_count);
    free = (sb.size() == 0) || rsp_ready[sb[0].owner];
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_rdy = (free && g >= 0) ? NUM_REQ'(1) << g : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (sb.size() != 0 && rsp_ready[sb[0].owner]) void'(sb.pop_front());
    if (free && g >= 0) begin
      sb.push_back('{owner: g,
                     res: m_alu(req_a[g*XLEN +: XLEN], req_b[g*XLEN +: XLEN],
                                req_op[g*OP_W +: OP_W])});
      m_ptr   = (g + 1) % NUM_REQ;
      m_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] op_a  [12];
  logic [31:0] op_b  [12];
  logic [3:0]  op_op [12];

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '0;
    model_reset();

    // Reset state, with a request pending to show req_ready stays low.
    set_req(0, 1'b1, 32'd5, 32'd3, ALU_ADD);
    #2;
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_result", rsp_result, 32'h0);
    check("reset_op_count", op_count, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester: 5 + 3.
    rsp_ready = 2'b01;
    step();
    set_req(0, 1'b0, 32'd5, 32'd3, ALU_ADD);
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_result", rsp_result, 32'd8);
    check("single_op_count", op_count, 32'd1);
    step();
    step();
    check("drain_holds_result", rsp_result, 32'd8);
    check("drain_clears_valid", 32'(rsp_valid), 32'h0);

    // Contention from a fresh pointer: grants alternate 0,1,0,1,0.
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    set_req(1, 1'b1, 32'd10, 32'd2, ALU_SUB);
    rsp_ready = 2'b11;
    for (int i = 0; i < 5; i++) step();
    req_valid = '0;
    step();

    // Backpressure: req1 SUB 0-1 held while its owner stalls.
    set_req(1, 1'b1, 32'd0, 32'd1, ALU_SUB);
    set_req(0, 1'b1, 32'd7, 32'd9, ALU_OR);
    rsp_ready = 2'b00;
    step();
    rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      check("bp_result_held", rsp_result, 32'hFFFF_FFFF);
      check("bp_all_ready_low", 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 2'b10;
    #1;
    check("bp_accept_on_release", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    rsp_ready = 2'b11;
    step();
    step();

    // Op coverage, one op per cycle from requester 0.
    op_a[0]  = 32'hFFFF_FFFF; op_b[0]  = 32'd1;  op_op[0]  = ALU_SLT;
    op_a[1]  = 32'hFFFF_FFFF; op_b[1]  = 32'd1;  op_op[1]  = ALU_SLTU;
    op_a[2]  = 32'h8000_0000; op_b[2]  = 32'h24; op_op[2]  = ALU_SRA;
    op_a[3]  = 32'h8000_0000; op_b[3]  = 32'h24; op_op[3]  = ALU_SRL;
    op_a[4]  = 32'h0000_0003; op_b[4]  = 32'd31; op_op[4]  = ALU_SLL;
    op_a[5]  = 32'h1234_5678; op_b[5]  = 32'h9;  op_op[5]  = ALU_INVALID;
    op_a[6]  = 32'h1234_5678; op_b[6]  = 32'h9;  op_op[6]  = ALU_NOP;
    op_a[7]  = 32'hF0F0_F0F0; op_b[7]  = 32'hFF00_FF00; op_op[7] = ALU_AND;
    op_a[8]  = 32'hF0F0_F0F0; op_b[8]  = 32'hFF00_FF00; op_op[8] = ALU_XOR;
    op_a[9]  = 32'hFFFF_FFFF; op_b[9]  = 32'd2;  op_op[9]  = ALU_ADD;
    op_a[10] = 32'd1;         op_b[10] = 32'd2;  op_op[10] = 4'hB;
    op_a[11] = 32'd1;         op_b[11] = 32'hFFFF_FFFF; op_op[11] = ALU_SLT;
    rsp_ready = 2'b11;
    for (int i = 0; i < 12; i++) begin
      set_req(0, 1'b1, op_a[i], op_b[i], op_op[i]);
      step();
    end
    req_valid = '0;
    check("slt_signed_last", rsp_result, 32'd0);
    step();

    // Reset asserted between edges while the slot is full.
    set_req(1, 1'b1, 32'hA5A5_0000, 32'h0000_5A5A, ALU_XOR);
    rsp_ready = 2'b00;
    step();
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    check("midhold_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midhold_op_count", op_count, 32'h0);
    check("midhold_req_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(0, 1'b1, 32'd2, 32'd2, ALU_ADD);
    set_req(1, 1'b1, 32'd3, 32'd3, ALU_ADD);
    rsp_ready = 2'b11;
    #1;
    check("first_grant_after_reset", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();

    // Counter wrap.
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    m_count = 32'hFFFF_FFFF;
    set_req(0, 1'b1, 32'd4, 32'd4, ALU_ADD);
    step();
    req_valid = '0;
    check("wrap_op_count", op_count, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
